// File: rtl/fft_host_sequencer_if.sv
// Bundle of host, datapath and status signals around the FFT host sequencer.
// The sequencer connects through the slave modport; the surrounding host and
// datapath environment connects through the master modport.
interface fft_host_sequencer_if #(
  parameter int W  = 8,
  parameter int AW = 3
);
  logic          i_start;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [W-1:0]  i_in_re;
  logic [W-1:0]  i_in_im;
  logic          o_load;
  logic [AW-1:0] o_load_addr;
  logic [W-1:0]  o_load_re;
  logic [W-1:0]  o_load_im;
  logic          o_transform;
  logic          i_done_transform;
  logic          o_read;
  logic [AW-1:0] o_read_addr;
  logic [W-1:0]  i_read_re;
  logic [W-1:0]  i_read_im;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [W-1:0]  o_out_re;
  logic [W-1:0]  o_out_im;
  logic          o_out_last;
  logic          o_busy;
  logic          o_done;
  logic          o_error;

  modport slave (
    input  i_start, i_in_valid, i_in_re, i_in_im, i_done_transform,
           i_read_re, i_read_im, i_out_ready,
    output o_in_ready, o_load, o_load_addr, o_load_re, o_load_im, o_transform,
           o_read, o_read_addr, o_out_valid, o_out_re, o_out_im, o_out_last,
           o_busy, o_done, o_error
  );

  modport master (
    output i_start, i_in_valid, i_in_re, i_in_im, i_done_transform,
           i_read_re, i_read_im, i_out_ready,
    input  o_in_ready, o_load, o_load_addr, o_load_re, o_load_im, o_transform,
           o_read, o_read_addr, o_out_valid, o_out_re, o_out_im, o_out_last,
           o_busy, o_done, o_error
  );
endinterface

// File: rtl/fft_host_sequencer.sv
// FFT host sequencer: accepts N samples in natural order and writes them to the
// datapath RAM in bit-reversed order, kicks the transform, waits for its
// completion edge (with timeout), then reads the N results back in order and
// streams them out. Samples are passed through untouched.
module fft_host_sequencer #(
  parameter int N       = 8,
  parameter int I       = 4,
  parameter int F       = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  fft_host_sequencer_if.slave bus
);
  localparam int W  = I + F;
  localparam int AW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   K_LAST = (AW + 1)'(N - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_XFORM, S_WAIT, S_RD_REQ, S_RD_CAP, S_RD_OUT, S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   k_q, k_d;          // one spare bit so k never wraps within a run
  logic [TW-1:0] timer_q, timer_d;
  logic          done_prev_q, done_prev_d;
  logic          error_q, error_d;
  logic          load_q, load_d;
  logic [AW-1:0] load_addr_q, load_addr_d;
  logic [W-1:0]  load_re_q, load_re_d;
  logic [W-1:0]  load_im_q, load_im_d;
  logic          transform_q, transform_d;
  logic [W-1:0]  out_re_q, out_re_d;
  logic [W-1:0]  out_im_q, out_im_d;

  logic          accept;
  logic          k_is_last;
  logic          done_rise;
  logic          timed_out;
  logic [AW-1:0] k_rev;

  logic          in_ready_c;
  logic          read_c;
  logic [AW-1:0] read_addr_c;
  logic          out_valid_c;
  logic          out_last_c;
  logic          busy_c;
  logic          done_c;

  // Bit-reversed RAM address of the current sample index.
  for (genvar gi = 0; gi < AW; gi++) begin : g_rev
    assign k_rev[gi] = k_q[AW-1-gi];
  end

  assign accept    = (state_q == S_LOAD) && bus.i_in_valid;
  assign k_is_last = (k_q == K_LAST);
  // Only a genuine 0->1 transition counts; a level already high does not.
  assign done_rise = bus.i_done_transform && !done_prev_q;
  assign timed_out = (timer_q == T_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.i_start) state_d = S_LOAD;
      S_LOAD:   if (accept && k_is_last) state_d = S_XFORM;
      S_XFORM:  state_d = S_WAIT;
      S_WAIT: begin
        if (done_rise)      state_d = S_RD_REQ;
        else if (timed_out) state_d = S_IDLE;
      end
      S_RD_REQ: state_d = S_RD_CAP;
      S_RD_CAP: state_d = S_RD_OUT;
      S_RD_OUT: if (bus.i_out_ready) state_d = k_is_last ? S_FIN : S_RD_REQ;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded directly from the current state.
  always_comb begin
    in_ready_c  = (state_q == S_LOAD);
    read_c      = (state_q == S_RD_REQ);
    read_addr_c = read_c ? k_q[AW-1:0] : '0;
    out_valid_c = (state_q == S_RD_OUT);
    out_last_c  = (state_q == S_RD_OUT) && k_is_last;
    busy_c      = (state_q != S_IDLE);
    done_c      = (state_q == S_FIN);
  end

  // Next values of the counters, load port, transform pulse and output data.
  always_comb begin
    k_d         = k_q;
    timer_d     = (state_q == S_WAIT) ? timer_q + TW'(1) : '0;
    done_prev_d = bus.i_done_transform;
    error_d     = error_q;
    load_d      = 1'b0;
    load_addr_d = load_addr_q;
    load_re_d   = load_re_q;
    load_im_d   = load_im_q;
    transform_d = (state_q == S_XFORM);
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          k_d     = '0;
          error_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          load_d      = 1'b1;
          load_addr_d = k_rev;
          load_re_d   = bus.i_in_re;
          load_im_d   = bus.i_in_im;
          k_d         = k_q + (AW + 1)'(1);
        end
      end
      S_WAIT: begin
        if (done_rise)      k_d     = '0;
        else if (timed_out) error_d = 1'b1;
      end
      S_RD_CAP: begin
        out_re_d = bus.i_read_re;
        out_im_d = bus.i_read_im;
      end
      S_RD_OUT: begin
        if (bus.i_out_ready && !k_is_last) k_d = k_q + (AW + 1)'(1);
      end
      default: ;
    endcase
  end

  // Counter, flag and data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q         <= '0;
      timer_q     <= '0;
      done_prev_q <= 1'b0;
      error_q     <= 1'b0;
      load_q      <= 1'b0;
      load_addr_q <= '0;
      load_re_q   <= '0;
      load_im_q   <= '0;
      transform_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      k_q         <= k_d;
      timer_q     <= timer_d;
      done_prev_q <= done_prev_d;
      error_q     <= error_d;
      load_q      <= load_d;
      load_addr_q <= load_addr_d;
      load_re_q   <= load_re_d;
      load_im_q   <= load_im_d;
      transform_q <= transform_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign bus.o_in_ready  = in_ready_c;
  assign bus.o_load      = load_q;
  assign bus.o_load_addr = load_addr_q;
  assign bus.o_load_re   = load_re_q;
  assign bus.o_load_im   = load_im_q;
  assign bus.o_transform = transform_q;
  assign bus.o_read      = read_c;
  assign bus.o_read_addr = read_addr_c;
  assign bus.o_out_valid = out_valid_c;
  assign bus.o_out_re    = out_re_q;
  assign bus.o_out_im    = out_im_q;
  assign bus.o_out_last  = out_last_c;
  assign bus.o_busy      = busy_c;
  assign bus.o_done      = done_c;
  assign bus.o_error     = error_q;
endmodule

// File: doc/fft_host_sequencer.md
FFT_HOST_SEQUENCER -- requirements
Module: fft_host_sequencer

Interface
REQ-001 Parameter N, default 8: FFT length (power of two, >= 4); AW = log2(N).
REQ-002 Parameter I, default 4: integer bits of the fixed-point sample.
REQ-003 Parameter F, default 4: fraction bits; sample width W = I+F.
REQ-004 Parameter TIMEOUT, default 1024: maximum cycles spent waiting for transform completion.
REQ-005 clk  in  1  Single clock; all logic is rising-edge.
REQ-006 rst  in  1  Reset, asynchronous, active-high.
REQ-007 i_start  in  1  Begins one load/transform/read run; sampled in IDLE only.
REQ-008 i_in_valid, o_in_ready  in/out  1 each  Input sample handshake.
REQ-009 i_in_re, i_in_im  in  W each  Input sample, natural order.
REQ-010 o_load, o_load_addr, o_load_re, o_load_im  out  1/AW/W/W  Write port toward the datapath RAM.
REQ-011 o_transform  out  1  Single-cycle pulse that starts the datapath transform.
REQ-012 i_done_transform  in  1  Datapath completion level.
REQ-013 o_read, o_read_addr  out  1/AW  Result read request; data returns one cycle later.
REQ-014 i_read_re, i_read_im  in  W each  Result data.
REQ-015 o_out_valid, i_out_ready, o_out_re, o_out_im, o_out_last  out/in/out/out/out  1/1/W/W/1  Output sample handshake.
REQ-016 o_busy, o_done, o_error  out  1 each  Status: run active, run-complete pulse, sticky timeout flag.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, XFORM, WAIT, RD_REQ, RD_CAP, RD_OUT, FIN.
REQ-018 In IDLE, i_start=1 SHALL go to LOAD, clear the sample counter k and clear o_error; i_start SHALL be ignored in all other states.
REQ-019 In LOAD, o_in_ready SHALL be 1; every cycle with i_in_valid && o_in_ready SHALL be an accepted sample.
REQ-020 For the k-th accepted sample, o_load SHALL be 1 in the next cycle with o_load_addr = bit-reverse of k over AW bits and o_load_re/im = the sample; otherwise o_load SHALL be 0.
REQ-021 On the N-th accept (k=N-1), the FSM SHALL go to XFORM and o_in_ready SHALL drop in the following cycle.
REQ-022 XFORM SHALL last one cycle (the final o_load cycle); o_transform SHALL be 1 in exactly the next cycle, which is the first WAIT cycle.
REQ-023 WAIT SHALL exit to RD_REQ with k=0 on a rising edge of i_done_transform (previous sample 0, current sample 1); a level already high on entry SHALL NOT count.
REQ-024 If TIMEOUT cycles elapse in WAIT without a rising edge, the FSM SHALL set o_error=1 and return to IDLE with no output samples.
REQ-025 RD_REQ SHALL assert o_read=1 with o_read_addr=k for one cycle; RD_CAP SHALL register i_read_re/im into o_out_re/im.
REQ-026 In RD_OUT, o_out_valid SHALL be 1 and o_out_re/im SHALL be held until i_out_ready=1; o_out_last SHALL be 1 with the sample for k=N-1.
REQ-027 On an RD_OUT accept, the FSM SHALL go to RD_REQ with k+1, or to FIN if k=N-1.
REQ-028 FIN SHALL pulse o_done for one cycle and return to IDLE.
REQ-029 o_busy SHALL be 1 in every state except IDLE.
REQ-030 Data SHALL pass through unmodified at width W; the sequencer performs no arithmetic on samples.
REQ-031 Counter k SHALL be AW+1 bits and SHALL never wrap within a run.

Reset
REQ-032 rst=1 SHALL force IDLE immediately and clear k and the timeout counter.
REQ-033 Reset values SHALL be: all outputs 0, including o_in_ready, o_load, o_transform, o_read, o_out_valid, o_done, o_error and all data/address buses.
REQ-034 Reset mid-run SHALL abandon the run; no further o_load, o_read or o_out_valid SHALL occur until a new i_start.

Verification
REQ-035 N=8, i_start, 8 back-to-back samples k=0..7: o_load_addr sequence 0,4,2,6,1,5,3,7; o_transform is high exactly 2 cycles after the 8th accept.
REQ-036 i_done_transform held high from before WAIT, then a 0->1 edge 20 cycles later: no read before that edge; 8 o_read pulses follow with addr 0..7; o_out_last appears on the 8th output only.
REQ-037 i_out_ready low for 5 cycles on output 3: o_out_valid and o_out_re/im stay stable; no o_read is issued until the accept; o_done pulses once after output 7.
REQ-038 i_done_transform held 0 in WAIT: o_error=1 after 1024 cycles, FSM returns to IDLE, o_busy=0; the next i_start clears o_error.
REQ-039 rst asserted during LOAD after 3 accepts: all outputs are 0 asynchronously; a new run after reset loads from k=0 (o_load_addr 0 first).
REQ-040 i_in_valid gapped (every other cycle) and i_start pulsed during LOAD: the load order is still correct and the extra i_start has no effect.
